// File: rtl/matvec_row_sequencer.sv
// matvec_row_sequencer: latches one M x N matrix and an N-element vector,
// walks the rows through an external combinational inner_product stage one
// row per cycle, and collects the M dot products into a result vector that
// is handed off over a valid/ready handshake.

// One result slot: holds the full-width dot product for a single row.
module matvec_result_slot #(
    parameter int IPW = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [IPW-1:0] d,
    output logic [IPW-1:0] q
);

    // Capture the inner_product result when this slot's row is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end

endmodule

module matvec_row_sequencer #(
    parameter int M   = 4,
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int IPW = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M*N*DW-1:0]  in_matrix,
    input  logic [N*DW-1:0]    in_vector,
    output logic [N*DW-1:0]    ip_inp1,
    output logic [N*DW-1:0]    ip_inp2,
    input  logic [IPW-1:0]     ip_outp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [M*IPW-1:0]   out_vector,
    output logic               busy
);

    // Row counter is at least one bit so M=1 still has a legal counter.
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state;
    logic [RW-1:0]              row;
    logic [M-1:0][N*DW-1:0]     mat_q;   // packed layout matches in_matrix rows
    logic [N*DW-1:0]            vec_q;
    logic [M-1:0][IPW-1:0]      res;

    // Job control: accept in IDLE, step rows in RUN, hold results in DONE.
    // in_ready comes up one edge after reset release, so a request held
    // across reset is only taken on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            mat_q     <= '0;
            vec_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mat_q    <= in_matrix;
                        vec_q    <= in_vector;
                        row      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (row == RW'(M - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                DONE: begin
                    // New requests are ignored here even if they coincide
                    // with the output handshake; IDLE takes them next cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        row       <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row select toward inner_product; drive zeros whenever not in RUN.
    always_comb begin
        ip_inp1 = '0;
        ip_inp2 = '0;
        if (state == RUN) begin
            ip_inp2 = vec_q;
            for (int r = 0; r < M; r++)
                if (row == RW'(r)) ip_inp1 = mat_q[r];
        end
    end

    // Per-row result slots, overwritten in row order by the running job.
    for (genvar r = 0; r < M; r++) begin : g_slot
        matvec_result_slot #(.IPW(IPW)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .we    ((state == RUN) && (row == RW'(r))),
            .d     (ip_outp),
            .q     (res[r])
        );
    end

    assign out_vector = res;
    assign busy       = (state == RUN) || (state == DONE);

endmodule
